reg_byte_assembler: RTL
=======================

Name: reg_byte_assembler

Overview:
Sits directly downstream of the host bus interface synchroniser. It consumes that block's single-cycle write/read strobes, register number, byte select and data byte. It assembles 68k-style even/odd byte accesses into 16-bit register-file writes and reads, and generates the DTACK level that the bus interface forwards to the host.

Parameters:
RD_TIMEOUT, 15, cycles to wait for reg_ack_i before a read is abandoned (used only with REG_RD_TIMEOUT_EN)
TIMEOUT_W, 4, width of timeout counter; must hold RD_TIMEOUT

Ports:
clk  in  1  system clock
reset_i  in  1  reset, asynchronous, active-high
write_strobe_i  in  1  one-cycle write strobe from bus interface
read_strobe_i  in  1  one-cycle read strobe from bus interface
reg_num_i  in  4  register number accessed
bytesel_i  in  1  0=even (MSB) byte, 1=odd (LSB) byte
bytedata_i  in  8  byte written by host
reg_wr_o  out  1  one-cycle 16-bit register write pulse
reg_rd_o  out  1  register read request, level, held until ack
reg_num_o  out  4  register number for reg_wr_o/reg_rd_o
reg_wdata_o  out  16  assembled write word
reg_rdata_i  in  16  register read data, valid with reg_ack_i
reg_ack_i  in  1  read acknowledge, one cycle
bus_data_o  out  8  read byte returned to host
bus_dtack_o  out  1  1=ACK; feeds bus interface bus_dtack_i
overrun_o  out  1  sticky: strobe arrived while busy

Behaviour:
- Reset (async, any time incl. mid-read): FSM=IDLE; every output 0; hi_byte=0; rd_latch=0; rd_valid=0; overrun_o=0. reg_rd_o drops immediately.
- FSM states: IDLE, WR_PULSE, RD_REQ, DONE.
- IDLE + write_strobe_i, bytesel_i=0:
  - hi_byte<=bytedata_i; -> DONE.
  - reg_wr_o stays 0; rd_valid cleared.
- IDLE + write_strobe_i, bytesel_i=1:
  - reg_wdata_o<={hi_byte,bytedata_i}; reg_num_o<=reg_num_i; -> WR_PULSE.
  - WR_PULSE: reg_wr_o=1 for exactly one cycle (cycle after strobe); -> DONE.
  - hi_byte retained, so repeated odd writes reuse the last MSB. rd_valid cleared.
- IDLE + read_strobe_i, bytesel_i=1, rd_valid=1, reg_num_i==rd_num: bus_data_o<=rd_latch[7:0]; -> DONE; no register request.
- IDLE + read_strobe_i (any other case):
  - reg_num_o<=reg_num_i; rd_num<=reg_num_i; -> RD_REQ.
  - reg_rd_o=1 from the next cycle until reg_ack_i is sampled high.
  - On ack: rd_latch<=reg_rdata_i; rd_valid<=1; bus_data_o<=bytesel ? reg_rdata_i[7:0] : reg_rdata_i[15:8]; reg_rd_o<=0; -> DONE.
  - Ack in the same cycle reg_rd_o rises is legal.
- DONE: bus_dtack_o=1, held. DONE exits to IDLE and bus_dtack_o<=0 in the same cycle a new strobe is seen; that strobe is then processed from IDLE in that cycle.
- Write latency: strobe -> reg_wr_o 1 cycle; strobe -> bus_dtack_o 2 cycles (odd) / 1 cycle (even).
- Read latency: strobe -> dtack = ack latency + 1; cached odd read = 1 cycle.
- Strobe while in WR_PULSE or RD_REQ: ignored; overrun_o<=1 (sticky until reset).
- Simultaneous write_strobe_i and read_strobe_i: write wins; read ignored, no overrun.
- reg_ack_i outside RD_REQ: ignored.
- bus_dtack_o is 0 in IDLE, WR_PULSE and RD_REQ.

Optional Feature:
REG_RD_TIMEOUT_EN
- Defined: a counter runs in RD_REQ. After RD_TIMEOUT cycles with no ack:
  - reg_rd_o<=0; bus_data_o<=8'hFF; rd_valid<=0; -> DONE (dtack asserted).
  - A late ack is then ignored.
- Not defined: RD_REQ waits indefinitely; no counter logic is synthesised.

Test Plan:
- Write even 0x12 then odd 0x34 to reg 5 -> one reg_wr_o pulse, reg_num_o=5, reg_wdata_o=0x1234, 1 cycle after the odd strobe; dtack 1 after even strobe, 2 after odd.
- Read even reg 3, reg_rdata_i=0xBEEF acked 3 cycles after request -> bus_data_o=0xBE, dtack; then odd read reg 3 -> 0xEF in 1 cycle with no reg_rd_o.
- Odd read reg 4 after even read reg 3 -> new reg_rd_o issued, byte [7:0] of the new data returned.
- Assert reset_i mid-RD_REQ -> reg_rd_o, bus_dtack_o, overrun_o go 0 asynchronously; FSM=IDLE; next read is fresh.
- Strobe during RD_REQ -> ignored, overrun_o=1 and stays 1; read completes with the original data.
- With REG_RD_TIMEOUT_EN, RD_TIMEOUT=15, no ack -> after 15 cycles bus_data_o=0xFF, dtack=1, late ack ignored.

Source files
------------

// File: rtl/reg_byte_assembler_if.sv
// Host-side byte bus and 16-bit register-file port bundle for reg_byte_assembler.
// slave = the assembler itself, master = the surrounding bus interface / register file.
interface reg_byte_assembler_if;
    logic        write_strobe_i;
    logic        read_strobe_i;
    logic [3:0]  reg_num_i;
    logic        bytesel_i;
    logic [7:0]  bytedata_i;
    logic        reg_wr_o;
    logic        reg_rd_o;
    logic [3:0]  reg_num_o;
    logic [15:0] reg_wdata_o;
    logic [15:0] reg_rdata_i;
    logic        reg_ack_i;
    logic [7:0]  bus_data_o;
    logic        bus_dtack_o;
    logic        overrun_o;

    modport slave (
        input  write_strobe_i, read_strobe_i, reg_num_i, bytesel_i, bytedata_i,
        input  reg_rdata_i, reg_ack_i,
        output reg_wr_o, reg_rd_o, reg_num_o, reg_wdata_o,
        output bus_data_o, bus_dtack_o, overrun_o
    );

    modport master (
        output write_strobe_i, read_strobe_i, reg_num_i, bytesel_i, bytedata_i,
        output reg_rdata_i, reg_ack_i,
        input  reg_wr_o, reg_rd_o, reg_num_o, reg_wdata_o,
        input  bus_data_o, bus_dtack_o, overrun_o
    );
endinterface

// File: rtl/reg_byte_assembler.sv
// Assembles 68k even/odd byte accesses into 16-bit register writes/reads and drives DTACK.
// Optional read abandon timer enabled by defining REG_RD_TIMEOUT_EN.
//
// state    | meaning
// IDLE     | waiting for a strobe, dtack low
// WR_PULSE | reg_wr_o high for one cycle
// RD_REQ   | reg_rd_o held, waiting for reg_ack_i
// DONE     | access complete, dtack held until next strobe
module reg_byte_assembler #(
    parameter int RD_TIMEOUT = 15,
    parameter int TIMEOUT_W  = 4
) (
    input logic                  clk,
    input logic                  reset_i,
    reg_byte_assembler_if.slave  bus
);

    if (RD_TIMEOUT < 1 || RD_TIMEOUT >= (1 << TIMEOUT_W)) begin : g_bad_timeout_cfg
        $error("RD_TIMEOUT does not fit in TIMEOUT_W bits");
    end

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_PULSE = 2'd1,
        RD_REQ   = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t      state;
    logic [7:0]  hi_byte;
    logic [15:0] rd_latch;
    logic        rd_valid;
    logic [3:0]  rd_num;
    logic        rd_bytesel;
`ifdef REG_RD_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] rd_timer;
`endif

    logic strobe_any;
    logic cached_hit;

    assign strobe_any = bus.write_strobe_i | bus.read_strobe_i;
    // Only the odd byte can be served from the word latched by a preceding even read.
    assign cached_hit = bus.bytesel_i & rd_valid & (bus.reg_num_i == rd_num);

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state           <= IDLE;
            hi_byte         <= '0;
            rd_latch        <= '0;
            rd_valid        <= 1'b0;
            rd_num          <= '0;
            rd_bytesel      <= 1'b0;
            bus.reg_wr_o    <= 1'b0;
            bus.reg_rd_o    <= 1'b0;
            bus.reg_num_o   <= '0;
            bus.reg_wdata_o <= '0;
            bus.bus_data_o  <= '0;
            bus.bus_dtack_o <= 1'b0;
            bus.overrun_o   <= 1'b0;
`ifdef REG_RD_TIMEOUT_EN
            rd_timer        <= '0;
`endif
        end else begin
            case (state)
                // DONE takes a new strobe exactly as IDLE would, dropping dtack unless the
                // new access completes immediately.
                IDLE, DONE: begin
                    if (bus.write_strobe_i) begin
                        rd_valid <= 1'b0;
                        if (!bus.bytesel_i) begin
                            hi_byte         <= bus.bytedata_i;
                            bus.bus_dtack_o <= 1'b1;
                            state           <= DONE;
                        end else begin
                            bus.reg_wdata_o <= {hi_byte, bus.bytedata_i};
                            bus.reg_num_o   <= bus.reg_num_i;
                            bus.reg_wr_o    <= 1'b1;
                            bus.bus_dtack_o <= 1'b0;
                            state           <= WR_PULSE;
                        end
                    end else if (bus.read_strobe_i) begin
                        if (cached_hit) begin
                            bus.bus_data_o  <= rd_latch[7:0];
                            bus.bus_dtack_o <= 1'b1;
                            state           <= DONE;
                        end else begin
                            bus.reg_num_o   <= bus.reg_num_i;
                            rd_num          <= bus.reg_num_i;
                            rd_bytesel      <= bus.bytesel_i;
                            bus.reg_rd_o    <= 1'b1;
                            bus.bus_dtack_o <= 1'b0;
                            state           <= RD_REQ;
`ifdef REG_RD_TIMEOUT_EN
                            rd_timer        <= TIMEOUT_W'(RD_TIMEOUT - 1);
`endif
                        end
                    end
                end

                WR_PULSE: begin
                    if (strobe_any) begin
                        bus.overrun_o <= 1'b1;
                    end
                    bus.reg_wr_o    <= 1'b0;
                    bus.bus_dtack_o <= 1'b1;
                    state           <= DONE;
                end

                RD_REQ: begin
                    if (strobe_any) begin
                        bus.overrun_o <= 1'b1;
                    end
                    if (bus.reg_ack_i) begin
                        rd_latch        <= bus.reg_rdata_i;
                        rd_valid        <= 1'b1;
                        bus.bus_data_o  <= rd_bytesel ? bus.reg_rdata_i[7:0] : bus.reg_rdata_i[15:8];
                        bus.reg_rd_o    <= 1'b0;
                        bus.bus_dtack_o <= 1'b1;
                        state           <= DONE;
                    end
`ifdef REG_RD_TIMEOUT_EN
                    else if (rd_timer == '0) begin
                        rd_valid        <= 1'b0;
                        bus.bus_data_o  <= 8'hFF;
                        bus.reg_rd_o    <= 1'b0;
                        bus.bus_dtack_o <= 1'b1;
                        state           <= DONE;
                    end else begin
                        rd_timer <= rd_timer - 1'b1;
                    end
`endif
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
